// File: rtl/ping_array_driver.sv
`default_nettype none
// ============================================================================
// Module   : ping_array_driver
// Purpose  : Round-robin trigger/echo controller for CHANNELS ultrasonic
//            sensors; echo width is timed in clk cycles and scaled to mm.
// Revision : 1.0 - initial multi-channel release
// ============================================================================
module ping_array_driver #(
  parameter  int CHANNELS    = 4,
  parameter  int WIDTH       = 16,
  parameter  int CNT_W       = 16,
  parameter  int TRIG_LOW    = 5,
  parameter  int TRIG_HIGH   = 5,
  parameter  int HOLDOFF     = 5,
  parameter  int TIMEOUT     = 19985,
  parameter  int SCALE_NUM   = 87,
  parameter  int SCALE_SHIFT = 9,
  localparam int CH_W        = (CHANNELS > 1) ? $clog2(CHANNELS) : 1
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic [CHANNELS-1:0] channel_enable,
  input  logic [CHANNELS-1:0] sensor_in,
  output logic [CHANNELS-1:0] sensor_out,
  output logic [CHANNELS-1:0] sensor_oe,
  output logic [WIDTH-1:0]    distance,
  output logic [CH_W-1:0]     channel,
  output logic                data_valid,
  output logic                timeout,
  output logic                busy,
  output logic [2:0]          state
);

  localparam logic [2:0] c_IDLE    = 3'd0;
  localparam logic [2:0] c_LOW_1   = 3'd1;
  localparam logic [2:0] c_HIGH    = 3'd2;
  localparam logic [2:0] c_LOW_2   = 3'd3;
  localparam logic [2:0] c_LISTEN  = 3'd4;
  localparam logic [2:0] c_MEASURE = 3'd5;
  localparam logic [2:0] c_RESULT  = 3'd6;
  localparam logic [2:0] c_NEXT    = 3'd7;

  localparam int              c_PROD_W   = CNT_W + 16;
  localparam logic [CNT_W-1:0] c_LOW1_END = CNT_W'(TRIG_LOW - 1);
  localparam logic [CNT_W-1:0] c_HIGH_END = CNT_W'(TRIG_HIGH - 1);
  localparam logic [CNT_W-1:0] c_LOW2_END = CNT_W'(HOLDOFF - 1);
  localparam logic [CNT_W-1:0] c_TIMEOUT  = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] c_ONE      = CNT_W'(1);

  logic [2:0]          r_state;
  logic [2:0]          w_state_next;
  logic [CH_W-1:0]     r_cur;
  logic [CNT_W-1:0]    r_timer;
  logic [CNT_W-1:0]    r_pulse;
  logic [CHANNELS-1:0] r_sync1;
  logic [CHANNELS-1:0] r_sync2;
  logic [CHANNELS-1:0] r_sync3;
  logic                r_rise;
  logic                r_fall;
  logic [WIDTH-1:0]    r_distance;
  logic [CH_W-1:0]     r_channel;
  logic                r_data_valid;
  logic                r_timeout;

  logic                w_any;
  logic                w_expire;
  logic                w_window;
  logic [CH_W-1:0]     w_pick_at;
  logic [CH_W-1:0]     w_pick_after;
  logic [c_PROD_W-1:0] w_prod;
  logic [c_PROD_W-1:0] w_scaled;
  logic [WIDTH-1:0]    w_dist;

  // (base + off) modulo CHANNELS, valid for any channel count
  function automatic logic [CH_W-1:0] f_wrap(input logic [CH_W-1:0] base, input int off);
    logic [CH_W:0] s;
    s = {1'b0, base} + (CH_W+1)'(off % CHANNELS);
    if (s >= (CH_W+1)'(CHANNELS)) s = s - (CH_W+1)'(CHANNELS);
    return s[CH_W-1:0];
  endfunction

  // Descending scan so the nearest enabled channel wins
  always_comb begin
    w_any        = |channel_enable;
    w_pick_at    = r_cur;
    w_pick_after = r_cur;
    for (int i = CHANNELS - 1; i >= 0; i--) begin
      if (channel_enable[f_wrap(r_cur, i)])     w_pick_at    = f_wrap(r_cur, i);
      if (channel_enable[f_wrap(r_cur, i + 1)]) w_pick_after = f_wrap(r_cur, i + 1);
    end
  end

  assign w_expire = (r_timer == c_TIMEOUT);
  assign w_window = (r_state == c_LISTEN) || (r_state == c_MEASURE);

  assign w_prod   = c_PROD_W'(r_pulse) * c_PROD_W'(SCALE_NUM);
  assign w_scaled = w_prod >> SCALE_SHIFT;

  generate
    if (WIDTH < c_PROD_W) begin : g_sat
      assign w_dist = (|w_scaled[c_PROD_W-1:WIDTH]) ? {WIDTH{1'b1}} : w_scaled[WIDTH-1:0];
    end else begin : g_nosat
      assign w_dist = WIDTH'(w_scaled);
    end
  endgenerate

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) r_state <= c_IDLE;
    else        r_state <= w_state_next;
  end

  always_comb begin
    w_state_next = r_state;
    case (r_state)
      c_IDLE:    if (enable && w_any) w_state_next = c_LOW_1;
      c_LOW_1:   if (r_timer == c_LOW1_END) w_state_next = c_HIGH;
      c_HIGH:    if (r_timer == c_HIGH_END) w_state_next = c_LOW_2;
      c_LOW_2:   if (r_timer == c_LOW2_END) w_state_next = c_LISTEN;
      // Window expiry outranks a same-cycle edge: the echo did not fit
      c_LISTEN: begin
        if (w_expire)    w_state_next = c_NEXT;
        else if (r_rise) w_state_next = c_MEASURE;
      end
      c_MEASURE: begin
        if (w_expire)    w_state_next = c_NEXT;
        else if (r_fall) w_state_next = c_RESULT;
      end
      c_RESULT:  w_state_next = c_NEXT;
      c_NEXT:    w_state_next = (enable && w_any) ? c_LOW_1 : c_IDLE;
      default:   w_state_next = c_IDLE;
    endcase
  end

  always_comb begin
    sensor_oe  = '0;
    sensor_out = '0;
    case (r_state)
      c_LOW_1, c_LOW_2: sensor_oe[r_cur] = 1'b1;
      c_HIGH: begin
        sensor_oe[r_cur]  = 1'b1;
        sensor_out[r_cur] = 1'b1;
      end
      default: ;
    endcase
    busy = (r_state != c_IDLE);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_sync3 <= '0;
      r_rise  <= 1'b0;
      r_fall  <= 1'b0;
    end else begin
      r_sync1 <= sensor_in;
      r_sync2 <= r_sync1;
      r_sync3 <= r_sync2;
      r_rise  <= r_sync2[r_cur] & ~r_sync3[r_cur];
      r_fall  <= ~r_sync2[r_cur] & r_sync3[r_cur];
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_cur   <= '0;
      r_timer <= '0;
      r_pulse <= '0;
    end else begin
      if (r_state == c_IDLE && enable && w_any) r_cur <= w_pick_at;
      else if (r_state == c_NEXT && w_any)      r_cur <= w_pick_after;

      // MEASURE keeps the LISTEN window timer running
      if (w_state_next != r_state && w_state_next != c_MEASURE && w_state_next != c_RESULT
          && w_state_next != c_NEXT && w_state_next != c_IDLE)
        r_timer <= '0;
      else if (r_state != c_IDLE)
        r_timer <= r_timer + c_ONE;

      // The detected rising edge already represents the first high sample
      if (r_state == c_LISTEN && w_state_next == c_MEASURE)
        r_pulse <= c_ONE;
      else if (r_state == c_MEASURE && r_sync3[r_cur] && r_pulse != '1)
        r_pulse <= r_pulse + c_ONE;
      else if (r_state != c_LOW_1 && w_state_next == c_LOW_1)
        r_pulse <= '0;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_distance   <= '0;
      r_channel    <= '0;
      r_data_valid <= 1'b0;
      r_timeout    <= 1'b0;
    end else begin
      r_data_valid <= (r_state == c_RESULT);
      r_timeout    <= w_window && w_expire;
      if (r_state == c_RESULT) begin
        r_distance <= w_dist;
        r_channel  <= r_cur;
      end else if (w_window && w_expire) begin
        r_channel  <= r_cur;
      end
    end
  end

  assign distance   = r_distance;
  assign channel    = r_channel;
  assign data_valid = r_data_valid;
  assign timeout    = r_timeout;
  assign state      = r_state;

endmodule
`default_nettype wire

// File: tb/tb_ping_array_driver.sv
`default_nettype none
// ============================================================================
// Module   : tb_ping_array_driver
// Purpose  : Directed/randomised bench for ping_array_driver, 4 channels, WIDTH=8.
// Revision : 1.0
// ============================================================================
module tb_ping_array_driver;

  localparam int CH          = 4;
  localparam int WIDTH       = 8;
  localparam int TRIG_LOW    = 5;
  localparam int TRIG_HIGH   = 5;
  localparam int HOLDOFF     = 5;
  localparam int TIMEOUT     = 19985;
  localparam int SCALE_NUM   = 87;
  localparam int SCALE_SHIFT = 9;

  logic             clk = 1'b0;
  logic             reset;
  logic             enable;
  logic [CH-1:0]    channel_enable;
  logic [CH-1:0]    sensor_in;
  logic [CH-1:0]    sensor_out;
  logic [CH-1:0]    sensor_oe;
  logic [WIDTH-1:0] distance;
  logic [1:0]       channel;
  logic             data_valid;
  logic             timeout;
  logic             busy;
  logic [2:0]       state;

  int n_vec, n_err;
  int m_cur, m_dist, m_chan;
  int exp_ch;

  ping_array_driver #(
    .CHANNELS(CH), .WIDTH(WIDTH), .CNT_W(16), .TRIG_LOW(TRIG_LOW), .TRIG_HIGH(TRIG_HIGH),
    .HOLDOFF(HOLDOFF), .TIMEOUT(TIMEOUT), .SCALE_NUM(SCALE_NUM), .SCALE_SHIFT(SCALE_SHIFT)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .channel_enable(channel_enable),
    .sensor_in(sensor_in), .sensor_out(sensor_out), .sensor_oe(sensor_oe),
    .distance(distance), .channel(channel), .data_valid(data_valid),
    .timeout(timeout), .busy(busy), .state(state)
  );

  always #5 clk = ~clk;

  // Reference: mm from pulse length with saturation to WIDTH bits
  function automatic int exp_dist(input int len);
    int v;
    v = (len * SCALE_NUM) / (1 << SCALE_SHIFT);
    if (v > (1 << WIDTH) - 1) v = (1 << WIDTH) - 1;
    return v;
  endfunction

  // Reference: round-robin choice of the next enabled channel
  function automatic int next_en(input int cur, input logic [CH-1:0] m, input bit incl);
    int c;
    for (int k = (incl ? 0 : 1); k <= CH; k++) begin
      c = (cur + k) % CH;
      if (m[2'(c)]) return c;
    end
    return cur;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_vec++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  task automatic wait_state(input logic [2:0] want, input int bound, input string tag);
    int n;
    n = 0;
    while (state !== want && n < bound) begin
      @(negedge clk);
      n++;
    end
    check(tag, 32'(state), 32'(want));
  endtask

  // Watch one trigger sequence; returns at the first sample inside LISTEN
  task automatic run_trigger(input int ch);
    logic [CH-1:0] soe, sout;
    int dur, hi;
    wait_state(3'd1, 64, "low1_entry");
    check("pulse_cleared", 32'(data_valid | timeout), 0);
    check("busy_trig", 32'(busy), 1);
    soe = '0; sout = '0; dur = 0; hi = 0;
    while (state !== 3'd4 && dur < 64) begin
      soe  |= sensor_oe;
      sout |= sensor_out;
      if (sensor_out != '0) hi++;
      dur++;
      @(negedge clk);
    end
    check("trig_oe_chan", 32'(soe), 32'(1 << ch));
    check("trig_out_chan", 32'(sout), 32'(1 << ch));
    check("trig_high_len", hi, TRIG_HIGH);
    check("trig_seq_len", dur, TRIG_LOW + TRIG_HIGH + HOLDOFF);
    check("listen_oe", 32'(sensor_oe), 0);
    m_cur = ch;
  endtask

  task automatic do_echo(input logic [1:0] ch, input int d, input int len, input bit drop_en);
    int bad;
    bad = 0;
    repeat (d - 1) begin
      @(negedge clk);
      bad += int'(data_valid | timeout);
    end
    sensor_in[ch] = 1'b1;
    for (int i = 0; i < len; i++) begin
      @(negedge clk);
      bad += int'(data_valid | timeout);
      if (drop_en && i == len / 2) enable = 1'b0;
    end
    sensor_in[ch] = 1'b0;
    repeat (4) begin
      @(negedge clk);
      bad += int'(data_valid | timeout);
    end
    check("echo_quiet", bad, 0);
    @(negedge clk);
    check("dv_pulse", 32'(data_valid), 1);
    check("dv_no_timeout", 32'(timeout), 0);
    check("distance", 32'(distance), exp_dist(len));
    check("channel", 32'(channel), 32'(ch));
    m_dist = exp_dist(len);
    m_chan = int'(ch);
  endtask

  task automatic do_timeout(input logic [1:0] ch, input bit hold_high);
    int bad;
    bad = 0;
    for (int i = 1; i <= TIMEOUT; i++) begin
      @(negedge clk);
      bad += int'(data_valid | timeout);
      if (hold_high && i == 99) sensor_in[ch] = 1'b1;
    end
    check("window_quiet", bad, 0);
    @(negedge clk);
    check("to_pulse", 32'(timeout), 1);
    check("to_no_dv", 32'(data_valid), 0);
    check("to_channel", 32'(channel), 32'(ch));
    check("to_distance_kept", 32'(distance), m_dist);
    sensor_in[ch] = 1'b0;
    m_chan = int'(ch);
  endtask

  initial begin
    reset = 1'b0; enable = 1'b0; channel_enable = '0; sensor_in = '0;
    n_vec = 0; n_err = 0; m_cur = 0; m_dist = 0; m_chan = 0;
    repeat (3) @(negedge clk);
    check("rst_state", 32'(state), 0);
    check("rst_oe", 32'(sensor_oe), 0);
    check("rst_out", 32'(sensor_out), 0);
    check("rst_distance", 32'(distance), 0);
    check("rst_channel", 32'(channel), 0);
    check("rst_dv", 32'(data_valid), 0);
    check("rst_timeout", 32'(timeout), 0);
    check("rst_busy", 32'(busy), 0);
    reset = 1'b1;
    @(negedge clk);
    check("idle_when_disabled", 32'(state), 0);
    channel_enable = 4'b1111;
    enable = 1'b1;

    exp_ch = next_en(m_cur, channel_enable, 1'b1);
    run_trigger(exp_ch);
    do_echo(2'(exp_ch), 100, 1000, 1'b0);
    check("dist_169", 32'(distance), 169);

    exp_ch = next_en(m_cur, channel_enable, 1'b0);
    run_trigger(exp_ch);
    do_echo(2'(exp_ch), $urandom_range(200, 1), 1, 1'b0);

    exp_ch = next_en(m_cur, channel_enable, 1'b0);
    run_trigger(exp_ch);
    do_timeout(2'(exp_ch), 1'b0);
    check("timeout_on_ch2", 32'(channel), 2);

    exp_ch = next_en(m_cur, channel_enable, 1'b0);
    run_trigger(exp_ch);
    do_echo(2'(exp_ch), $urandom_range(200, 1), $urandom_range(1200, 1), 1'b0);

    exp_ch = next_en(m_cur, channel_enable, 1'b0);
    run_trigger(exp_ch);
    do_echo(2'(exp_ch), 50, 2000, 1'b0);
    check("dist_saturated", 32'(distance), 255);

    for (int r = 0; r < 4; r++) begin
      exp_ch = next_en(m_cur, channel_enable, 1'b0);
      run_trigger(exp_ch);
      if (r == 3) channel_enable = 4'b1010;
      do_echo(2'(exp_ch), $urandom_range(200, 1), $urandom_range(1200, 1), 1'b0);
    end

    for (int r = 0; r < 4; r++) begin
      exp_ch = next_en(m_cur, channel_enable, 1'b0);
      run_trigger(exp_ch);
      if (r == 3) channel_enable = 4'b0000;
      do_echo(2'(exp_ch), $urandom_range(200, 1), $urandom_range(1200, 1), 1'b0);
    end
    @(negedge clk);
    check("mask0_idle", 32'(state), 0);
    check("mask0_busy", 32'(busy), 0);

    channel_enable = 4'b0010;
    exp_ch = next_en(m_cur, channel_enable, 1'b1);
    wait_state(3'd2, 64, "high_entry");
    check("high_oe", 32'(sensor_oe), 32'(1 << exp_ch));
    check("high_out", 32'(sensor_out), 32'(1 << exp_ch));
    reset = 1'b0;
    #1;
    check("async_oe", 32'(sensor_oe), 0);
    check("async_out", 32'(sensor_out), 0);
    check("async_state", 32'(state), 0);
    check("async_busy", 32'(busy), 0);
    m_cur = 0; m_dist = 0; m_chan = 0;
    channel_enable = 4'b1111;
    @(negedge clk);
    check("rst2_distance", 32'(distance), 0);
    reset = 1'b1;

    exp_ch = next_en(m_cur, channel_enable, 1'b1);
    run_trigger(exp_ch);
    do_timeout(2'(exp_ch), 1'b1);

    exp_ch = next_en(m_cur, channel_enable, 1'b0);
    run_trigger(exp_ch);
    do_echo(2'(exp_ch), $urandom_range(200, 1), $urandom_range(1200, 2), 1'b1);
    @(negedge clk);
    check("en_drop_idle", 32'(state), 0);
    check("en_drop_busy", 32'(busy), 0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
`default_nettype wire
